// File: rtl/d_sramlike_bridge_pkg.sv
// Shared types and constants for the data-side SRAM-like bridge.
package d_sramlike_bridge_pkg;

    // Handshake FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ADDR = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_DONE      = 2'd3
    } state_e;

    // SRAM-like transfer size codes.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/d_sramlike_bridge_wen2size.sv
// Maps the decoder's byte write-enable pattern to an SRAM-like size code.
module wen2size
    import d_sramlike_bridge_pkg::*;
(
    input  logic [3:0] wen_i,
    output logic [1:0] size_o
);

    // One-hot -> byte, aligned pair -> half; anything else is treated as a word.
    always_comb begin
        size_o = SIZE_W;
        case (wen_i)
            4'b1111:                            size_o = SIZE_W;
            4'b0011, 4'b1100:                   size_o = SIZE_H;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SIZE_B;
            default:                            size_o = SIZE_W;
        endcase
    end

endmodule

// File: rtl/d_sramlike_bridge.sv
// Data-side bridge: turns one M-stage access into exactly one SRAM-like
// transaction, stalls until data_ok, and holds the result through other stalls.
module d_sramlike_bridge
    import d_sramlike_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [1:0]  load_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        longest_stall,
    output logic [31:0] mem_rdata,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    state_e      state_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [1:0]  st_size;
    logic        live_wr;
    logic [1:0]  live_size;
    logic        in_idle;
    logic        data_hit;

    wen2size u_wen2size (
        .wen_i  (mem_wen),
        .size_o (st_size)
    );

    assign live_wr   = |mem_wen;
    assign live_size = live_wr ? st_size : load_size;
    assign in_idle   = (state_q == S_IDLE);
    assign data_hit  = (state_q == S_WAIT_DATA) && data_data_ok;

    // Live fields on the first request cycle, registered copies afterwards so
    // the bus sees stable values while addr_ok is pending.
    assign data_req   = ~rst & ((in_idle & mem_en) | (state_q == S_WAIT_ADDR));
    assign data_wr    = in_idle ? live_wr   : wr_q;
    assign data_size  = in_idle ? live_size : size_q;
    assign data_addr  = in_idle ? mem_addr  : addr_q;
    assign data_wdata = in_idle ? mem_wdata : wdata_q;

    // Stall drops on the data_ok cycle and stays low while parked in DONE.
    assign d_stall   = ~rst & mem_en & (state_q != S_DONE) & ~data_hit;
    assign mem_rdata = rst ? 32'h0 : (data_hit ? data_rdata : rdata_q);

    // Handshake FSM plus request field and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_en) begin
                        wr_q    <= live_wr;
                        size_q  <= live_size;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        state_q <= data_addr_ok ? S_WAIT_DATA : S_WAIT_ADDR;
                    end
                end
                S_WAIT_ADDR: begin
                    if (data_addr_ok) state_q <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    if (data_data_ok) begin
                        rdata_q <= data_rdata;
                        state_q <= longest_stall ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!longest_stall) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
